// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width and the
// frame-request sequencer state encoding.
package uart_pkg;

  localparam int unsigned DataWDefault = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SHIFT,
    WAIT_DONE
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Synchronous FIFO storage with wrap-bit pointers and full/empty flags.
// Pointer outputs exist only when UART_TX_FIFO_STATUS_EN is defined.
module uart_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [ADDR_W:0]   wr_ptr_o,
  output logic [ADDR_W:0]   rd_ptr_o
`endif
);

  localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              wr_fire, rd_fire;

  // Full is judged on the pre-pop state, so a write while full is dropped
  // even if a pop happens on the same edge.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign wr_fire   = wr_en_i & ~full_o;
  assign rd_fire   = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
  end

`ifdef UART_TX_FIFO_STATUS_EN
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
`endif

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus frame-request sequencer feeding the UART TX PISO controller.
// Define UART_TX_FIFO_STATUS_EN to add the level and sticky overflow outputs.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              baud_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  input  logic              load,
  input  logic              shift,
  output logic              send,
  output logic [DATA_W-1:0] tx_data
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [ADDR_W:0]   level,
  output logic              overflow
`endif
);

  tx_fifo_state_t state_q, state_d;
  logic           send_q, send_d;
  logic           pop;

`ifdef UART_TX_FIFO_STATUS_EN
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic            overflow_q, overflow_d;
`endif

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i     (baud_clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (tx_data),
    .full_o    (full),
    .empty_o   (empty)
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr)
`endif
  );

  // Only REQ consumes load, so a late or repeated load cannot double-pop.
  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = REQ;
          send_d  = 1'b1;
        end
      end
      REQ: begin
        if (load) begin
          pop     = 1'b1;
          send_d  = 1'b0;
          state_d = WAIT_SHIFT;
        end
      end
      WAIT_SHIFT: if (shift) state_d = WAIT_DONE;
      WAIT_DONE:  if (!shift) state_d = IDLE;
      default: begin
        state_d = IDLE;
        send_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
    end
  end

  assign send = send_q;

`ifdef UART_TX_FIFO_STATUS_EN
  assign overflow_d = overflow_q | (wr_en & full);

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign level    = wr_ptr - rd_ptr;
  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus directed sequences.
// Status checks are compiled in when UART_TX_FIFO_STATUS_EN is defined.
module tb_uart_tx_fifo;

  logic       baud_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       load     = 1'b0;
  logic       shift    = 1'b0;
  logic       full, empty, send;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_STATUS_EN
  logic [3:0] level;
  logic       overflow;
`endif

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(
    .DATA_W (8),
    .DEPTH  (8)
  ) dut (
    .baud_clk (baud_clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .load     (load),
    .shift    (shift),
    .send     (send),
    .tx_data  (tx_data)
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    .level    (level),
    .overflow (overflow)
`endif
  );

  always #5 baud_clk = ~baud_clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       load;
    logic       shift;
    int         rep;
    logic       exp_send;
    logic       exp_empty;
    logic       exp_full;
    logic       chk_tx;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    wr_en = 1'b0;
    load  = 1'b0;
    shift = 1'b0;
    repeat (3) @(posedge baud_clk);
    #1;
    check({tag, " rst send"}, send, 1'b0);
    check({tag, " rst empty"}, empty, 1'b1);
    check({tag, " rst full"}, full, 1'b0);
`ifdef UART_TX_FIFO_STATUS_EN
    check({tag, " rst level"}, level, 4'd0);
    check({tag, " rst overflow"}, overflow, 1'b0);
`endif
    #2 rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  // Wait (bounded) for send, check the head byte and the wait length, then accept it.
  task automatic frame(input logic [7:0] exp, input int exp_wait, input string tag);
    int n = 0;
    while (send !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, " send"}, send, 1'b1);
    check({tag, " wait"}, n, exp_wait);
    check({tag, " tx_data"}, tx_data, exp);
    load = 1'b1;
    step();
    load = 1'b0;
    check({tag, " send drop"}, send, 1'b0);
  endtask

  task automatic do_shift(input string tag);
    shift = 1'b1;
    repeat (11) step();
    shift = 1'b0;
    step();
    check({tag, " gap"}, send, 1'b0);
  endtask

  initial begin
    //            wr    data   ld    sh   rep  send  empty full  chk   tx
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    do_reset("single");
    for (int i = 0; i < 13; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      load    = vecs[i].load;
      shift   = vecs[i].shift;
      repeat (vecs[i].rep) step();
      check($sformatf("vec%0d send", i), send, vecs[i].exp_send);
      check($sformatf("vec%0d empty", i), empty, vecs[i].exp_empty);
      check($sformatf("vec%0d full", i), full, vecs[i].exp_full);
      if (vecs[i].chk_tx) check($sformatf("vec%0d tx_data", i), tx_data, vecs[i].exp_tx);
    end
    wr_en = 1'b0;
    load  = 1'b0;
    shift = 1'b0;

    // Ordered burst: each request appears exactly one IDLE cycle after shift falls.
    do_reset("burst");
    push(8'h01);
    push(8'h02);
    push(8'h03);
    frame(8'h01, 0, "burst f1");
    do_shift("burst f1");
    frame(8'h02, 1, "burst f2");
    do_shift("burst f2");
    frame(8'h03, 1, "burst f3");
    do_shift("burst f3");
    check("burst empty", empty, 1'b1);
    step();
    check("burst idle send", send, 1'b0);

    // Fill to DEPTH with no load, then push one more.
    do_reset("ovf");
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    check("ovf full", full, 1'b1);
    check("ovf send", send, 1'b1);
`ifdef UART_TX_FIFO_STATUS_EN
    check("ovf level8", level, 4'd8);
    check("ovf flag clear", overflow, 1'b0);
`endif
    push(8'h3C);
    check("ovf still full", full, 1'b1);
    check("ovf head", tx_data, 8'h10);
`ifdef UART_TX_FIFO_STATUS_EN
    check("ovf level", level, 4'd8);
    check("ovf flag", overflow, 1'b1);
`endif

    // Push and pop on the same edge with 3 entries in REQ.
    do_reset("sim");
    push(8'h20);
    push(8'h21);
    push(8'h22);
    check("sim send", send, 1'b1);
    check("sim head", tx_data, 8'h20);
    wr_en   = 1'b1;
    wr_data = 8'h23;
    load    = 1'b1;
    step();
    wr_en   = 1'b0;
    load    = 1'b0;
    check("sim send drop", send, 1'b0);
    check("sim empty", empty, 1'b0);
    check("sim new head", tx_data, 8'h21);
`ifdef UART_TX_FIFO_STATUS_EN
    check("sim level", level, 4'd3);
`endif
    do_shift("sim f0");
    frame(8'h21, 1, "sim f1");
    do_shift("sim f1");
    frame(8'h22, 1, "sim f2");
    do_shift("sim f2");
    frame(8'h23, 1, "sim f3");
    check("sim drained", empty, 1'b1);
    do_shift("sim f3");

    // Asynchronous reset in the middle of a request.
    push(8'h40);
    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("mrst send before", send, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst send", send, 1'b0);
    check("mrst empty", empty, 1'b1);
    check("mrst full", full, 1'b0);
    repeat (3) @(posedge baud_clk);
    #2 rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (send !== 1'b0) seen = 1'b1;
      end
      check("mrst no send", seen, 1'b0);
    end
    push(8'h77);
    frame(8'h77, 1, "mrst new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and frame-request sequencer placed directly upstream of the UART transmit PISO controller. Software/host logic pushes bytes into a small synchronous FIFO; the block presents the head byte on `tx_data`, raises `send`, and pops the entry once the controller acknowledges with `load`. It then waits for the controller's `shift` activity to start and finish before requesting the next frame. Frames therefore go out back-to-back, in order, without host pacing.

## Interface
- `DATA_W`, 8: byte width presented to the PISO.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `ADDR_W`, `$clog2(DEPTH)`: pointer index width (derived, not overridden).

- `baud_clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push request; sampled each edge.
- `wr_data`  in  DATA_W  byte to push.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `load`  in  1  from controller: frame accepted, head byte captured this cycle.
- `shift`  in  1  from controller: frame bits being shifted.
- `send`  out  1  frame request to controller; registered.
- `tx_data`  out  DATA_W  head-of-FIFO byte; valid while `send`=1.
- `level`  out  ADDR_W+1  occupancy (only with `UART_TX_FIFO_STATUS_EN`).
- `overflow`  out  1  sticky dropped-write flag (only with `UART_TX_FIFO_STATUS_EN`).

## Operation
- Storage: DEPTH×DATA_W array. Read and write pointers are ADDR_W+1 bits and wrap naturally. `empty` = pointers equal. `full` = MSBs differ and low bits equal.
- Push: when `wr_en`=1 and `full`=0, write `wr_data` at wr_ptr and increment wr_ptr. When `full`=1, the write is dropped. This holds even if a pop occurs in the same cycle, because `full` is evaluated before the pop.
- Pop: happens only in state REQ on an edge where `load`=1. It increments rd_ptr.
- Simultaneous push and pop when not full: both take effect, and occupancy is unchanged.
- `tx_data` = mem[rd_ptr low bits], combinational. It is stable for the whole of REQ.
- FSM states: IDLE, REQ, WAIT_SHIFT, WAIT_DONE.
  - IDLE: if `empty`=0, go to REQ and set `send`←1.
  - REQ: hold `send`=1 until `load`=1. On that edge: pop, set `send`←0, go to WAIT_SHIFT.
  - WAIT_SHIFT: when `shift`=1, go to WAIT_DONE.
  - WAIT_DONE: when `shift`=0, go to IDLE.
- `load` or `shift` asserted in IDLE is ignored.
- `load` asserted in WAIT_* is ignored, so no double pop.

## Timing
- Reset values: `send`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0, both pointers 0, state IDLE. `tx_data` shows mem[0], which is don't-care.
- Reset asserted mid-operation: FIFO contents are discarded and outputs return to reset values immediately (asynchronous).
- Write latency: push at edge N gives `empty`=0 after edge N. The FSM leaves IDLE at edge N+1, so `send`=1 during cycle N+1→N+2.
- `send` falls on the same edge that samples `load`=1.
- Minimum inter-frame gap: one IDLE cycle after `shift` falls before `send` re-asserts.

## Configuration
- `UART_TX_FIFO_STATUS_EN` defined:
  - `level` = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
  - `overflow` is set on any edge with `wr_en`=1 and `full`=1, and is cleared only by reset.
- `UART_TX_FIFO_STATUS_EN` undefined: `level` and `overflow` ports and their logic are absent. Drop-on-full behaviour is unchanged.

## Structure
- Shared package `uart_pkg`: the `DATA_W` default and the state enum typedef `tx_fifo_state_t` {IDLE, REQ, WAIT_SHIFT, WAIT_DONE}.
- One sub-module, `uart_fifo_mem`: storage array, pointers, and full/empty flags. The top level holds the FSM and the status logic.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `send`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0.
- Single byte: push 0xA5 → `send`=1 one cycle later with `tx_data`=0xA5. Pulse `load` → `send`=0 the same edge and `empty`=1. Pulse `shift` high for 11 cycles, then low → FSM back in IDLE.
- Ordered burst: push 0x01, 0x02, 0x03 → three frames requested in that order, each `send` only after the previous `shift` falls.
- Overflow: push 8 bytes (DEPTH=8) with no `load` → `full`=1 and `level`=8. Push 0x3C → dropped, `overflow`=1, and the head byte stays the first pushed.
- Simultaneous: FIFO at 3 entries in REQ; `wr_en`=1 and `load`=1 on the same edge → `level` stays 3 and the new byte is appended at the tail.
- Reset mid-REQ: deassert `rst_n` while `send`=1 with 4 entries → `send`=0 and `empty`=1 immediately. After release, no `send` until a new push.
